// File: rtl/soft_i2c_pkg.sv
// Shared encodings for the soft I2C target: FSM states, ACK/NACK levels, default address.
package soft_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } slv_state_e;

    localparam logic       I2C_ACK            = 1'b0;
    localparam logic       I2C_NACK           = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h66;
    localparam logic [2:0] BIT_MSB            = 3'd7;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr);
    endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// SCL/SDA synchronizers, optional 3-sample deglitch (`define SOFT_I2C_SLAVE_GLITCH_FILTER_EN),
// and registered edge / START / STOP detection.
module i2c_bus_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_lvl_o,
    output logic sda_lvl_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_raw_s;
    logic                   sda_raw_s;
    logic                   scl_lvl_s;
    logic                   sda_lvl_s;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   scl_q;
    logic                   sda_q;

    // Idle bus level is high, so synchronizers reset to 1 to avoid a false event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_raw_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_raw_s = sda_sync_q[SYNC_STAGES-1];

`ifdef SOFT_I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    // Filtered level follows the input only when the current and two previous samples agree.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_raw_s};
            sda_hist_q <= {sda_hist_q[0], sda_raw_s};
            scl_filt_q <= scl_lvl_s;
            sda_filt_q <= sda_lvl_s;
        end
    end

    assign scl_lvl_s = (scl_hist_q == {2{scl_raw_s}}) ? scl_raw_s : scl_filt_q;
    assign sda_lvl_s = (sda_hist_q == {2{sda_raw_s}}) ? sda_raw_s : sda_filt_q;
`else
    assign scl_lvl_s = scl_raw_s;
    assign sda_lvl_s = sda_raw_s;
`endif

    // Edge and bus-condition detection against one registered copy of each line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl_s;
            sda_prev_q <= sda_lvl_s;
            scl_rise_q <= scl_lvl_s & ~scl_prev_q;
            scl_fall_q <= ~scl_lvl_s & scl_prev_q;
            start_q    <= scl_lvl_s & scl_prev_q & sda_prev_q & ~sda_lvl_s;
            stop_q     <= scl_lvl_s & scl_prev_q & ~sda_prev_q & sda_lvl_s;
            scl_q      <= scl_lvl_s;
            sda_q      <= sda_lvl_s;
        end
    end

    assign scl_lvl_o  = scl_q;
    assign sda_lvl_o  = sda_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/soft_i2c_slave.sv
// I2C target serving a byte-wide register file: pointer write, then data write or read with
// auto-increment. Input deglitching is selected by `define SOFT_I2C_SLAVE_GLITCH_FILTER_EN.
module soft_i2c_slave
    import soft_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oe_o,
    output logic          wr_strobe_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

    slv_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic          byte_done_q;
    logic [7:0]    shift_q;
    logic          rw_q;
    logic          master_ack_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic          sda_oe_q;
    logic          busy_q;
    logic          wr_strobe_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;

    logic          scl_lvl_s;
    logic          sda_lvl_s;
    logic          scl_rise_s;
    logic          scl_fall_s;
    logic          start_s;
    logic          stop_s;
    logic [AW-1:0] ptr_inc_s;
    logic [7:0]    rd_byte_s;

    i2c_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_lvl_o  (scl_lvl_s),
        .sda_lvl_o  (sda_lvl_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    assign ptr_inc_s = ptr_q + AW'(1'b1);
    assign rd_byte_s = regs_q[ptr_q];

    // Protocol FSM: bits sampled on SCL rise, SDA only changed on SCL fall; START/STOP win.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= BIT_MSB;
            byte_done_q  <= 1'b0;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            master_ack_q <= I2C_NACK;
            ptr_q        <= '0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            if (stop_s) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_s) begin
                state_q     <= ST_ADDR;
                bit_cnt_q   <= BIT_MSB;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else if (scl_rise_s && scl_lvl_s) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shift_q     <= {shift_q[6:0], sda_lvl_s};
                        byte_done_q <= (bit_cnt_q == 3'd0);
                        bit_cnt_q   <= bit_cnt_q - 3'd1;
                    end
                    ST_RDATA: begin
                        byte_done_q <= (bit_cnt_q == 3'd0);
                        bit_cnt_q   <= bit_cnt_q - 3'd1;
                    end
                    ST_RDATA_ACK: begin
                        master_ack_q <= sda_lvl_s;
                        if (sda_lvl_s == I2C_ACK) begin
                            ptr_q <= ptr_inc_s;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall_s) begin
                case (state_q)
                    ST_ADDR: begin
                        if (byte_done_q) begin
                            byte_done_q <= 1'b0;
                            bit_cnt_q   <= BIT_MSB;
                            if (addr_match(shift_q, SLAVE_ADDR)) begin
                                rw_q     <= shift_q[0];
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= ST_ADDR_ACK;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt_q   <= BIT_MSB;
                        byte_done_q <= 1'b0;
                        if (rw_q) begin
                            shift_q  <= rd_byte_s;
                            sda_oe_q <= ~rd_byte_s[7];
                            state_q  <= ST_RDATA;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_PTR;
                        end
                    end
                    ST_PTR: begin
                        if (byte_done_q) begin
                            byte_done_q <= 1'b0;
                            bit_cnt_q   <= BIT_MSB;
                            ptr_q       <= shift_q[AW-1:0];
                            sda_oe_q    <= 1'b1;
                            state_q     <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: begin
                        if (byte_done_q) begin
                            byte_done_q   <= 1'b0;
                            bit_cnt_q     <= BIT_MSB;
                            regs_q[ptr_q] <= shift_q;
                            wr_strobe_q   <= 1'b1;
                            wr_addr_q     <= ptr_q;
                            wr_data_q     <= shift_q;
                            ptr_q         <= ptr_inc_s;
                            sda_oe_q      <= 1'b1;
                            state_q       <= ST_WDATA_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_WDATA;
                    end
                    ST_RDATA: begin
                        if (byte_done_q) begin
                            byte_done_q  <= 1'b0;
                            sda_oe_q     <= 1'b0;
                            master_ack_q <= I2C_NACK;
                            state_q      <= ST_RDATA_ACK;
                        end else begin
                            shift_q  <= {shift_q[6:0], 1'b0};
                            sda_oe_q <= ~shift_q[6];
                        end
                    end
                    ST_RDATA_ACK: begin
                        // Pointer was already advanced on the ACK rise, so this loads the next byte.
                        if (master_ack_q == I2C_ACK) begin
                            bit_cnt_q <= BIT_MSB;
                            shift_q   <= rd_byte_s;
                            sda_oe_q  <= ~rd_byte_s[7];
                            state_q   <= ST_RDATA;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_IGNORE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_o       = 1'b0;
    assign sda_oe_o    = sda_oe_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_soft_i2c_slave.sv
// Self-checking bench for soft_i2c_slave: bench-side I2C master plus a register-file/pointer model.
module tb_soft_i2c_slave;

    localparam int         Q   = 8;
    localparam logic [6:0] SLV = 7'h66;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_o_w;
    logic       sda_oe;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    logic [7:0] ref_regs [16];
    int         ref_ptr = 0;
    logic [7:0] wbuf [16];
    int         got_addr [$];
    int         got_data [$];
    logic       oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    soft_i2c_slave dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .scl_i       (scl),
        .sda_i       (sda_line),
        .sda_o       (sda_o_w),
        .sda_oe_o    (sda_oe),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic bit_xfer(input logic b_out, output logic b_in);
        wait_clk(Q);
        sda_m = b_out; wait_clk(Q);
        scl = 1'b1;    wait_clk(Q);
        b_in = sda_line; wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_m, output logic [7:0] b, output logic rel);
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, b[i]);
        bit_xfer(ack_m, rel);
    endtask

    task automatic wr_txn(input logic [7:0] ptr, input int n);
        logic a;
        int   ea [16];
        got_addr.delete(); got_data.delete();
        i2c_start();
        write_byte({SLV, 1'b0}, a); chk("wr_addr_ack", a, 1'b0);
        chk("busy_wr", busy, 1'b1);
        write_byte(ptr, a); chk("wr_ptr_ack", a, 1'b0);
        ref_ptr = int'(ptr) % 16;
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], a); chk("wr_data_ack", a, 1'b0);
            ea[k] = ref_ptr;
            ref_regs[ref_ptr] = wbuf[k];
            ref_ptr = (ref_ptr + 1) % 16;
        end
        i2c_stop();
        chk("busy_after_wr", busy, 1'b0);
        chk("strobe_count", got_addr.size(), n);
        for (int k = 0; k < n && k < got_addr.size(); k++) begin
            chk("strobe_addr", got_addr[k], ea[k]);
            chk("strobe_data", got_data[k], int'(wbuf[k]));
        end
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n);
        logic       a;
        logic       rel;
        logic [7:0] d;
        logic       last;
        got_addr.delete(); got_data.delete();
        i2c_start();
        if (set_ptr) begin
            write_byte({SLV, 1'b0}, a); chk("rd_waddr_ack", a, 1'b0);
            write_byte(ptr, a); chk("rd_ptr_ack", a, 1'b0);
            ref_ptr = int'(ptr) % 16;
            i2c_start();
        end
        write_byte({SLV, 1'b1}, a); chk("rd_addr_ack", a, 1'b0);
        chk("busy_rd", busy, 1'b1);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            read_byte(last, d, rel);
            chk("rd_data", d, ref_regs[ref_ptr]);
            if (last) chk("rd_release", rel, 1'b1);
            else ref_ptr = (ref_ptr + 1) % 16;
        end
        i2c_stop();
        chk("busy_after_rd", busy, 1'b0);
        chk("rd_no_strobe", got_addr.size(), 0);
    endtask

    initial begin
        logic       a;
        logic       d;
        logic [7:0] b;
        logic [7:0] p;
        int         n;

        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        wait_clk(4);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_sda_o", sda_o_w, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_clk(4);

        // Single write then read-back through a repeated START.
        wbuf[0] = 8'hA5;
        wr_txn(8'h01, 1);
        rd_txn(1'b1, 8'h01, 1);

        // Foreign address: no ACK, following bytes ignored.
        got_addr.delete(); got_data.delete();
        oe_seen = 1'b0;
        i2c_start();
        write_byte({7'h1A, 1'b0}, a); chk("foreign_addr_nack", a, 1'b1);
        chk("foreign_busy", busy, 1'b0);
        write_byte(8'h01, a); chk("foreign_b1_nack", a, 1'b1);
        write_byte(8'h77, a); chk("foreign_b2_nack", a, 1'b1);
        i2c_stop();
        chk("foreign_oe_never", oe_seen, 1'b0);
        chk("foreign_no_strobe", got_addr.size(), 0);
        rd_txn(1'b1, 8'h01, 1);

        // Pointer wrap on burst write and burst read.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        wr_txn(8'h0F, 2);
        rd_txn(1'b1, 8'h0F, 2);

        // STOP after half a data byte: nothing written, pointer retained.
        got_addr.delete(); got_data.delete();
        i2c_start();
        write_byte({SLV, 1'b0}, a); chk("part_addr_ack", a, 1'b0);
        write_byte(8'h03, a); chk("part_ptr_ack", a, 1'b0);
        ref_ptr = 3;
        b = 8'hC3;
        for (int i = 7; i >= 4; i--) bit_xfer(b[i], d);
        i2c_stop();
        chk("part_no_strobe", got_addr.size(), 0);
        chk("part_busy", busy, 1'b0);
        rd_txn(1'b0, 8'h00, 1);

        // Randomized bursts against the model.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            p = 8'($urandom_range(0, 255));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
            wr_txn(p, n);
            n = $urandom_range(1, 4);
            p = 8'($urandom_range(0, 255));
            rd_txn(1'($urandom_range(0, 1)), p, n);
        end

        // Reset while the slave is driving a data ACK.
        got_addr.delete(); got_data.delete();
        i2c_start();
        write_byte({SLV, 1'b0}, a); chk("rst_case_addr_ack", a, 1'b0);
        write_byte(8'h05, a); chk("rst_case_ptr_ack", a, 1'b0);
        b = 8'h5A;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        wait_clk(Q);
        chk("ack_driven", sda_oe, 1'b1);
        chk("rst_case_strobe_cnt", got_addr.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("oe_async_reset", sda_oe, 1'b0);
        chk("busy_async_reset", busy, 1'b0);
        wait_clk(4);
        rst_n = 1'b1;
        i2c_stop();
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        ref_ptr = 0;
        rd_txn(1'b0, 8'h00, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
